execute_stage: RTL and testbench

- Consumer end of the 155-bit ID/EX bundle produced by instruction decode.
- Unpacks the bundle, selects operands, runs the ALU, resolves branches, and registers results into a 71-bit EX/MEM bundle.
- Multiply is iterative (32 cycles) and stalls upstream through a `stall` output.

---
 rtl/execute_stage_pkg.sv | 78 +++++++
 rtl/execute_stage_if.sv | 22 ++
 rtl/execute_stage_seq_multiplier.sv | 62 ++++++
 rtl/execute_stage.sv | 115 +++++++++++
 tb/tb_execute_stage.sv | 187 ++++++++++++++++++
 5 files changed

// File: rtl/execute_stage_pkg.sv
// Shared definitions for the execute stage: bundle layouts, ALU opcodes and
// the multiply sequencing states.
package execute_pkg;

    localparam int IDEX_W  = 155;
    localparam int EXMEM_W = 71;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SLL   = 4'd5;
    localparam logic [3:0] ALU_SRL   = 4'd6;
    localparam logic [3:0] ALU_SRA   = 4'd7;
    localparam logic [3:0] ALU_SLT   = 4'd8;
    localparam logic [3:0] ALU_MUL   = 4'd9;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // ID/EX bit offsets (LSB of each field)
    localparam int IDEX_OPTYPE_LSB = 153;
    localparam int IDEX_OPCODE_LSB = 149;
    localparam int IDEX_IMMSRC     = 148;
    localparam int IDEX_BRANCH     = 147;
    localparam int IDEX_MEMWRITE   = 146;
    localparam int IDEX_MEMTOREG   = 145;
    localparam int IDEX_REGWRITE   = 144;
    localparam int IDEX_ALUCTL_LSB = 140;
    localparam int IDEX_RA_LSB     = 136;
    localparam int IDEX_RD1_LSB    = 104;
    localparam int IDEX_RB_LSB     = 100;
    localparam int IDEX_RD2_LSB    = 68;
    localparam int IDEX_RC_LSB     = 64;
    localparam int IDEX_RD3_LSB    = 32;
    localparam int IDEX_IMM_LSB    = 0;

    // EX/MEM bit offsets
    localparam int EXMEM_MEMWRITE  = 70;
    localparam int EXMEM_MEMTOREG  = 69;
    localparam int EXMEM_REGWRITE  = 68;
    localparam int EXMEM_RC_LSB    = 64;
    localparam int EXMEM_ALU_LSB   = 32;
    localparam int EXMEM_STORE_LSB = 0;

    typedef struct packed {
        logic [1:0]  op_type;
        logic [3:0]  op_code;
        logic        imm_src;
        logic        branch_flag;
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [3:0]  alu_control;
        logic [3:0]  ra;
        logic [31:0] rd1;
        logic [3:0]  rb;
        logic [31:0] rd2;
        logic [3:0]  rc;
        logic [31:0] rd3;
        logic [31:0] extend_imm;
    } idex_t;

    typedef struct packed {
        logic        mem_write;
        logic        mem_to_reg;
        logic        reg_write;
        logic [3:0]  rc;
        logic [31:0] alu_result;
        logic [31:0] store_data;
    } exmem_t;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

endpackage

// File: rtl/execute_stage_if.sv
// ID/EX -> EX/MEM boundary: decode side is the master, the execute stage the slave.
interface execute_stage_if;
    import execute_pkg::*;

    logic                 en;
    logic                 flush;
    logic [IDEX_W-1:0]    bufferIn;
    logic                 stall;
    logic                 branchTaken;
    logic [31:0]          branchTarget;
    logic [EXMEM_W-1:0]   bufferOut;

    modport master (
        output en, flush, bufferIn,
        input  stall, branchTaken, branchTarget, bufferOut
    );

    modport slave (
        input  en, flush, bufferIn,
        output stall, branchTaken, branchTarget, bufferOut
    );
endinterface

// File: rtl/execute_stage_seq_multiplier.sv
// Iterative shift-add multiplier, one partial product per step; keeps only the
// low WIDTH bits of the product.
module seq_multiplier #(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             start_i,
    input  logic             step_i,
    input  logic             abort_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] product_o,
    output logic             done_o
);
    localparam int CNT_W = $clog2(MUL_CYCLES) + 1;

    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        if (start_i) begin
            mcand_d  = a_i;
            mplier_d = b_i;
            acc_d    = '0;
            cnt_d    = '0;
        end else if (step_i) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = {mcand_q[WIDTH-2:0], 1'b0};
            mplier_d = {1'b0, mplier_q[WIDTH-1:1]};
            cnt_d    = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst || abort_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
        end
    end

    // Asserted on the step that completes the final partial product.
    assign done_o    = step_i && (cnt_q == CNT_W'(MUL_CYCLES - 1));
    assign product_o = acc_q;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand select, ALU, branch resolve and EX/MEM register, with
// an iterative multiply that stalls upstream until its result is ready.
module execute_stage
    import execute_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int MUL_CYCLES = 32
) (
    input logic            clk,
    input logic            rst,
    execute_stage_if.slave ex
);

    idex_t            idex;
    exmem_t           out_q, out_d;
    mul_state_e       state_q;
    logic [WIDTH-1:0] op1, op2, alu_result, product;
    logic [4:0]       shamt;
    logic             mul_req, mul_start, mul_step, mul_done;
    logic             stall;
    logic             branch_cond;
    logic             unused_fields;

    assign idex  = idex_t'(ex.bufferIn);
    assign op1   = idex.rd1;
    assign op2   = idex.imm_src ? idex.extend_imm : idex.rd2;
    assign shamt = op2[4:0];

    // opType, Ra, Rb and the upper opCode bits are carried for forwarding only.
    assign unused_fields = ^{idex.op_type, idex.op_code[3:1], idex.ra, idex.rb};

    always_comb begin
        alu_result = '0;
        case (idex.alu_control)
            ALU_ADD:   alu_result = op1 + op2;
            ALU_SUB:   alu_result = op1 - op2;
            ALU_AND:   alu_result = op1 & op2;
            ALU_OR:    alu_result = op1 | op2;
            ALU_XOR:   alu_result = op1 ^ op2;
            ALU_SLL:   alu_result = op1 << shamt;
            ALU_SRL:   alu_result = op1 >> shamt;
            ALU_SRA:   alu_result = $unsigned($signed(op1) >>> shamt);
            ALU_SLT:   alu_result = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
            ALU_PASSB: alu_result = op2;
            default:   alu_result = '0;
        endcase
    end

    assign mul_req   = (idex.alu_control == ALU_MUL);
    assign stall     = ((state_q == MUL_IDLE) && mul_req) || (state_q == MUL_BUSY);
    assign mul_start = (state_q == MUL_IDLE) && mul_req && ex.en && !ex.flush;
    assign mul_step  = (state_q == MUL_BUSY) && ex.en && !ex.flush;

    seq_multiplier #(
        .WIDTH      (WIDTH),
        .MUL_CYCLES (MUL_CYCLES)
    ) u_mul (
        .clk       (clk),
        .srst      (rst),
        .start_i   (mul_start),
        .step_i    (mul_step),
        .abort_i   (ex.flush),
        .a_i       (op1),
        .b_i       (op2),
        .product_o (product),
        .done_o    (mul_done)
    );

    always_comb begin
        out_d.mem_write  = idex.mem_write;
        out_d.mem_to_reg = idex.mem_to_reg;
        out_d.reg_write  = idex.reg_write;
        out_d.rc         = idex.rc;
        out_d.alu_result = (state_q == MUL_DONE) ? product : alu_result;
        out_d.store_data = idex.rd3;
    end

    // EX/MEM only loads when the stage is not stalled; DONE is never stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MUL_IDLE;
            out_q   <= '0;
        end else if (ex.flush) begin
            state_q <= MUL_IDLE;
            out_q   <= '0;
        end else if (ex.en) begin
            case (state_q)
                MUL_IDLE: begin
                    if (mul_req) begin
                        state_q <= MUL_BUSY;
                    end else begin
                        out_q <= out_d;
                    end
                end
                MUL_BUSY: begin
                    if (mul_done) begin
                        state_q <= MUL_DONE;
                    end
                end
                MUL_DONE: begin
                    out_q   <= out_d;
                    state_q <= MUL_IDLE;
                end
                default: state_q <= MUL_IDLE;
            endcase
        end
    end

    assign branch_cond     = idex.op_code[0] ? (idex.rd1 != idex.rd2) : (idex.rd1 == idex.rd2);
    assign ex.branchTaken  = !stall && idex.branch_flag && branch_cond;
    assign ex.branchTarget = stall ? 32'd0 : idex.extend_imm;
    assign ex.stall        = stall;
    assign ex.bufferOut    = out_q;

endmodule

// File: tb/tb_execute_stage.sv
// Randomized self-checking bench for execute_stage against an arithmetic model.
module tb_execute_stage;
    import execute_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    execute_stage_if ex_if();

    execute_stage #(
        .WIDTH      (32),
        .MUL_CYCLES (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ex  (ex_if)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [70:0] prev_out;

    task automatic check_eq(input string tag, input logic [70:0] got, input logic [70:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_alu(input logic [3:0] ctl, input logic [31:0] a,
                                            input logic [31:0] b);
        int              s;
        int              ia, ib;
        longint unsigned p;
        s  = int'(b[4:0]);
        ia = a;
        ib = b;
        p  = longint'(a) * longint'(b);
        case (ctl)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a & b;
            4'd3:  return a | b;
            4'd4:  return a ^ b;
            4'd5:  return a << s;
            4'd6:  return a >> s;
            4'd7:  return a[31] ? ((a >> s) | ~(32'hFFFF_FFFF >> s)) : (a >> s);
            4'd8:  return (ia < ib) ? 32'd1 : 32'd0;
            4'd9:  return p[31:0];
            4'd10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [154:0] mk_bundle(input logic [3:0] ctl, input logic [31:0] rd1,
            input logic [31:0] rd2, input logic [31:0] rd3, input logic [31:0] ext,
            input logic imm, input logic bflag, input logic opc0, input logic mw,
            input logic m2r, input logic rw, input logic [3:0] rc);
        logic [31:0] r;
        r = $urandom();
        return {r[1:0], r[4:2], opc0, imm, bflag, mw, m2r, rw, ctl,
                r[8:5], rd1, r[12:9], rd2, rc, rd3, ext};
    endfunction

    // Presents one bundle and checks branch outputs, stall length and EX/MEM result.
    task automatic do_op(input logic [3:0] ctl, input logic [31:0] rd1, input logic [31:0] rd2,
            input logic [31:0] rd3, input logic [31:0] ext, input logic imm, input logic bflag,
            input logic opc0, input logic mw, input logic m2r, input logic rw,
            input logic [3:0] rc, input int hold_at);
        logic [31:0] op2, res;
        logic [70:0] exp_out;
        logic        exp_taken;
        int          stalls;
        op2     = imm ? ext : rd2;
        res     = ref_alu(ctl, rd1, op2);
        exp_out = {mw, m2r, rw, rc, res, rd3};
        ex_if.bufferIn = mk_bundle(ctl, rd1, rd2, rd3, ext, imm, bflag, opc0, mw, m2r, rw, rc);
        ex_if.en = 1'b1;
        #1;
        if (ctl == 4'd9) begin
            check_eq("mul_stall_start", 71'(ex_if.stall), 71'd1);
            check_eq("mul_branch_forced", {ex_if.branchTaken, ex_if.branchTarget}, 71'd0);
            stalls = 0;
            while (ex_if.stall && stalls < 200) begin
                stalls++;
                ex_if.en = !(hold_at >= 0 && stalls > hold_at && stalls <= hold_at + 3);
                @(posedge clk);
                #1;
            end
            ex_if.en = 1'b1;
            check_eq("mul_stall_len", 71'(stalls), (hold_at >= 0) ? 71'd36 : 71'd33);
            check_eq("mul_out_held", ex_if.bufferOut, prev_out);
        end else begin
            exp_taken = bflag && (opc0 ? (rd1 != rd2) : (rd1 == rd2));
            check_eq("stall_low", 71'(ex_if.stall), 71'd0);
            check_eq("branch_taken", 71'(ex_if.branchTaken), 71'(exp_taken));
            check_eq("branch_target", 71'(ex_if.branchTarget), 71'(ext));
        end
        @(posedge clk);
        #1;
        check_eq("result", ex_if.bufferOut, exp_out);
        prev_out = exp_out;
        $display("op ctl=%0d op1=%h op2=%h -> result %h", ctl, rd1, op2, res);
    endtask

    initial begin
        logic [31:0] a, b, c, d, r;
        logic [3:0]  ctl;

        rst            = 1'b1;
        ex_if.en       = 1'b1;
        ex_if.flush    = 1'b0;
        ex_if.bufferIn = '0;
        prev_out       = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("reset_out", ex_if.bufferOut, 71'd0);
        rst = 1'b0;

        do_op(4'd0, 32'd5, 32'd7, 32'h1111, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd3, -1);
        do_op(4'd1, 32'd0, 32'd99, 32'h2222, 32'd1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd4, -1);
        do_op(4'd7, 32'h8000_0000, 32'd4, 32'h3333, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd5, -1);
        do_op(4'd9, 32'd1234, 32'd5678, 32'h4444, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd6, -1);
        do_op(4'd9, 32'hFFFF_FFFF, 32'd2, 32'h5555, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd7, -1);
        do_op(4'd0, 32'd9, 32'd9, 32'd0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1);
        do_op(4'd0, 32'd9, 32'd8, 32'd0, 32'h40, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, -1);

        // ADD held by en=0 for three cycles
        ex_if.bufferIn = mk_bundle(4'd0, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 4'd9);
        ex_if.en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check_eq("en_hold", ex_if.bufferOut, prev_out);
        end
        do_op(4'd0, 32'd100, 32'd23, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd9, -1);

        // en=0 for three BUSY cycles stretches the stall
        do_op(4'd9, 32'd777, 32'd31, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 10);

        // flush at BUSY cnt=10
        ex_if.bufferIn = mk_bundle(4'd9, 32'd3, 32'd5, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 4'd1);
        repeat (11) @(posedge clk);
        #1;
        check_eq("flush_pre_stall", 71'(ex_if.stall), 71'd1);
        ex_if.flush    = 1'b1;
        ex_if.bufferIn = mk_bundle(4'd0, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 4'd8);
        @(posedge clk);
        #1;
        ex_if.flush = 1'b0;
        check_eq("flush_bubble", ex_if.bufferOut, 71'd0);
        prev_out = '0;
        do_op(4'd0, 32'd40, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd8, -1);

        // reset at BUSY cnt=20; the next multiply must take the full time again
        ex_if.bufferIn = mk_bundle(4'd9, 32'd11, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0,
                                   1'b0, 1'b0, 1'b1, 4'd1);
        repeat (21) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_eq("rst_mid_mul", ex_if.bufferOut, 71'd0);
        prev_out = '0;
        do_op(4'd9, 32'd11, 32'd13, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd1, -1);

        for (int n = 0; n < 40; n++) begin
            a   = $urandom();
            b   = $urandom();
            c   = $urandom();
            d   = $urandom();
            r   = $urandom();
            ctl = (r[2:0] == 3'd0) ? 4'd9 : r[6:3];
            if (r[8:7] == 2'd0) b = a;
            if (r[9]) d = {27'd0, d[4:0]};
            do_op(ctl, a, b, c, d, r[10], r[11], r[12], r[13], r[14], r[15], r[19:16], -1);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
